// File: rtl/interrupt_controller.sv
// Four-source interrupt arbiter: edge-detects IRQ lines, latches them as pending,
// masks them, and hands the highest-priority unmasked source to the control unit.
module interrupt_controller (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] IRQ,
    input  logic       MaskWrite,
    input  logic [3:0] MaskData,
    input  logic       EPCWrite,
    input  logic       IntReturn,
    output logic       InterruptIn,
    output logic       InterruptHandler,
    output logic [1:0] IntCause,
    output logic [3:0] Pending,
    output logic [3:0] Mask
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] irqPrev_q;
    logic [3:0] pending_q, pending_d;
    logic [3:0] mask_q, mask_d;
    logic [1:0] cause_q, cause_d;

    logic [3:0] rise;
    logic [3:0] eligible;
    logic [3:0] clearVec;
    logic [1:0] winner;

    assign rise     = IRQ & ~irqPrev_q;
    assign eligible = pending_q & mask_q;

    // Bit 0 has the highest priority.
    always_comb begin
        winner = 2'd0;
        casez (eligible)
            4'b???1: winner = 2'd0;
            4'b??10: winner = 2'd1;
            4'b?100: winner = 2'd2;
            4'b1000: winner = 2'd3;
            default: winner = 2'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        clearVec = 4'b0000;
        case (state_q)
            IDLE: begin
                if (eligible != 4'b0000) begin
                    cause_d = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (EPCWrite) begin
                    clearVec = 4'b0001 << cause_q;
                    state_d  = SERVICE;
                end
            end
            SERVICE: begin
                if (IntReturn) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new edge on the bit being acknowledged survives the clear.
    assign pending_d = (pending_q & ~clearVec) | rise;
    assign mask_d    = MaskWrite ? MaskData : mask_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= IDLE;
            irqPrev_q <= IRQ;
            pending_q <= 4'b0000;
            mask_q    <= 4'b0000;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            irqPrev_q <= IRQ;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            cause_q   <= cause_d;
        end
    end

    assign InterruptIn      = (state_q == REQ);
    assign InterruptHandler = (state_q == SERVICE);
    assign IntCause         = cause_q;
    assign Pending          = pending_q;
    assign Mask             = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbiter.
module tb_interrupt_controller;

    logic       CLK;
    logic       CLR;
    logic [3:0] IRQ;
    logic       MaskWrite;
    logic [3:0] MaskData;
    logic       EPCWrite;
    logic       IntReturn;
    logic       InterruptIn;
    logic       InterruptHandler;
    logic [1:0] IntCause;
    logic [3:0] Pending;
    logic [3:0] Mask;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: mode 0 = waiting, 1 = requesting, 2 = in service.
    logic [3:0] mPrev = 4'b0000;
    logic [3:0] mPend = 4'b0000;
    logic [3:0] mMask = 4'b0000;
    int         mMode = 0;
    int         mCause = 0;

    interrupt_controller dut (
        .CLK(CLK),
        .CLR(CLR),
        .IRQ(IRQ),
        .MaskWrite(MaskWrite),
        .MaskData(MaskData),
        .EPCWrite(EPCWrite),
        .IntReturn(IntReturn),
        .InterruptIn(InterruptIn),
        .InterruptHandler(InterruptHandler),
        .IntCause(IntCause),
        .Pending(Pending),
        .Mask(Mask)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelEdge();
        logic [3:0] rise;
        logic [3:0] elig;
        logic [3:0] nextPend;
        int         lowest;
        if (CLR) begin
            mPrev  = IRQ;
            mPend  = 4'b0000;
            mMask  = 4'b0000;
            mMode  = 0;
            mCause = 0;
        end else begin
            rise     = IRQ & ~mPrev;
            mPrev    = IRQ;
            elig     = mPend & mMask;
            nextPend = mPend;
            if (mMode == 0) begin
                lowest = -1;
                for (int i = 3; i >= 0; i--) begin
                    if (elig[i]) lowest = i;
                end
                if (lowest >= 0) begin
                    mCause = lowest;
                    mMode  = 1;
                end
            end else if (mMode == 1) begin
                if (EPCWrite) begin
                    nextPend[mCause] = 1'b0;
                    mMode = 2;
                end
            end else begin
                if (IntReturn) mMode = 0;
            end
            mPend = nextPend | rise;
            if (MaskWrite) mMask = MaskData;
        end
    endtask

    task automatic compareAll();
        checkOutput("InterruptIn", {3'b000, InterruptIn}, (mMode == 1) ? 4'd1 : 4'd0);
        checkOutput("InterruptHandler", {3'b000, InterruptHandler}, (mMode == 2) ? 4'd1 : 4'd0);
        checkOutput("IntCause", {2'b00, IntCause}, 4'(mCause));
        checkOutput("Pending", Pending, mPend);
        checkOutput("Mask", Mask, mMask);
    endtask

    task automatic applyStimulus(input logic [3:0] irq, input logic mw, input logic [3:0] md,
                                 input logic epc, input logic ret, input logic clr);
        IRQ       = irq;
        MaskWrite = mw;
        MaskData  = md;
        EPCWrite  = epc;
        IntReturn = ret;
        CLR       = clr;
        @(posedge CLK);
        modelEdge();
        #1;
        compareAll();
    endtask

    logic [3:0] rIrq;

    initial begin
        IRQ = 4'b0000; MaskWrite = 1'b0; MaskData = 4'b0000;
        EPCWrite = 1'b0; IntReturn = 1'b0; CLR = 1'b1;
        #2;

        // Lines already high through reset must not become pending.
        applyStimulus(4'hF, 0, 4'h0, 0, 0, 1);
        applyStimulus(4'hF, 0, 4'h0, 0, 0, 1);
        checkOutput("resetPending", Pending, 4'b0000);
        checkOutput("resetReq", {3'b000, InterruptIn}, 4'd0);
        applyStimulus(4'hF, 1, 4'hF, 0, 0, 0);
        applyStimulus(4'hF, 0, 4'h0, 0, 0, 0);
        applyStimulus(4'hF, 0, 4'h0, 0, 0, 0);
        checkOutput("heldHighNoPend", Pending, 4'b0000);
        applyStimulus(4'h0, 0, 4'h0, 0, 0, 0);

        // Basic request on source 2 with a stray EPCWrite while idle.
        applyStimulus(4'h0, 0, 4'h0, 1, 0, 0);
        applyStimulus(4'h4, 0, 4'h0, 0, 0, 0);
        checkOutput("basicPending", Pending, 4'b0100);
        applyStimulus(4'h4, 0, 4'h0, 0, 0, 0);
        checkOutput("basicReq", {3'b000, InterruptIn}, 4'd1);
        checkOutput("basicCause", {2'b00, IntCause}, 4'd2);
        applyStimulus(4'h0, 0, 4'h0, 0, 1, 0);
        applyStimulus(4'h0, 0, 4'h0, 1, 0, 0);
        checkOutput("basicAckPend", Pending, 4'b0000);
        checkOutput("basicHandler", {3'b000, InterruptHandler}, 4'd1);
        applyStimulus(4'h0, 0, 4'h0, 0, 1, 0);
        applyStimulus(4'h0, 0, 4'h0, 0, 0, 0);

        // Simultaneous sources 3 and 1: source 1 first, then source 3.
        applyStimulus(4'hA, 0, 4'h0, 0, 0, 0);
        applyStimulus(4'hA, 0, 4'h0, 0, 0, 0);
        checkOutput("prioCause", {2'b00, IntCause}, 4'd1);
        applyStimulus(4'h0, 0, 4'h0, 1, 0, 0);
        applyStimulus(4'h0, 0, 4'h0, 0, 1, 0);
        applyStimulus(4'h0, 0, 4'h0, 0, 0, 0);
        checkOutput("prioSecond", {2'b00, IntCause}, 4'd3);
        applyStimulus(4'h0, 0, 4'h0, 1, 0, 0);
        applyStimulus(4'h0, 0, 4'h0, 0, 1, 0);

        // Masked source waits until enabled.
        applyStimulus(4'h0, 1, 4'h0, 0, 0, 0);
        applyStimulus(4'h1, 0, 4'h0, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(4'h1, 0, 4'h0, 0, 0, 0);
        applyStimulus(4'h0, 1, 4'h1, 0, 0, 0);
        applyStimulus(4'h0, 0, 4'h0, 0, 0, 0);
        checkOutput("unmaskReq", {3'b000, InterruptIn}, 4'd1);

        // New edge on source 0 on its own ack edge stays pending, no nesting.
        applyStimulus(4'h1, 0, 4'h0, 1, 0, 0);
        checkOutput("setWinsPend", Pending, 4'b0001);
        for (int i = 0; i < 5; i++) applyStimulus(4'h1, 0, 4'h0, 0, 0, 0);
        applyStimulus(4'h0, 0, 4'h0, 0, 1, 0);
        applyStimulus(4'h0, 0, 4'h0, 0, 0, 0);
        checkOutput("reReqCause", {2'b00, IntCause}, 4'd0);

        // Reset while requesting.
        applyStimulus(4'h0, 0, 4'h0, 0, 0, 1);
        checkOutput("midReqReset", {3'b000, InterruptIn}, 4'd0);
        applyStimulus(4'h0, 1, 4'hF, 0, 0, 0);

        // Random traffic.
        rIrq = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3) == 0) rIrq[b] = ~rIrq[b];
            end
            applyStimulus(rIrq,
                          ($urandom_range(15) == 0),
                          4'($urandom_range(15)),
                          ($urandom_range(2) == 0),
                          ($urandom_range(2) == 0),
                          ($urandom_range(199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Four-source interrupt arbiter feeding the multi-cycle control unit. It edge-detects external requests, latches them as pending, applies a software-writable mask, and picks the highest-priority unmasked source. It raises `InterruptIn` until the control unit acknowledges by saving the EPC, then holds `InterruptHandler` until return-from-interrupt. The datapath uses `IntCause` to select the handler vector.

## Interface
- No parameters. Source count is fixed at 4 and cause width at 2.
- `CLK` in 1: system clock. All state changes occur on the rising edge.
- `CLR` in 1: synchronous, active-high reset.
- `IRQ` in 4: external request lines, level inputs, rising-edge sensitive. Bit 0 has the highest priority.
- `MaskWrite` in 1: when high, load `MaskData` into the mask register.
- `MaskData` in 4: new mask value. 1 = source enabled.
- `EPCWrite` in 1: acknowledge pulse from the control unit (EPC saved, jump to handler).
- `IntReturn` in 1: pulse from the control unit on return-from-interrupt.
- `InterruptIn` out 1: interrupt request to the control unit.
- `InterruptHandler` out 1: high while a handler is in service. The control unit uses it to block nesting.
- `IntCause` out 2: index of the source being requested or serviced.
- `Pending` out 4: pending-request register, readable by software.
- `Mask` out 4: current mask register.

## Operation
- Edge detect:
  - `irq_prev` is a 4-bit register loaded with `IRQ` every cycle.
  - `rise = IRQ & ~irq_prev`.
  - During `CLR`, `irq_prev` loads the live `IRQ`, so lines already high at reset never create a pending bit.
- Pending update, every cycle: `Pending <= (Pending & ~clear) | rise`.
  - `clear` is the one-hot of `IntCause`, active only on the cycle the state machine accepts an `EPCWrite` in REQ.
  - If set and clear hit the same bit in the same cycle, set wins: a new edge stays pending.
- Mask: `Mask <= MaskData` when `MaskWrite` is high, in any state. The comparison logic always uses the registered (old) value in that cycle.
- `eligible = Pending & Mask`. Winner = lowest set index of `eligible`.
- State machine, 2-bit encoding:
  - IDLE (00). If `eligible != 0`, latch the winner into `IntCause` and go to REQ. Otherwise stay.
  - REQ (01). `InterruptIn` = 1. On `EPCWrite` = 1, clear that pending bit and go to SERVICE. Otherwise stay.
  - SERVICE (10). `InterruptHandler` = 1. On `IntReturn` = 1, go to IDLE. Otherwise stay.
  - Code 11 is illegal and returns to IDLE on the next edge.
- Once latched in REQ, `IntCause` does not change. This holds even if a higher-priority source arrives or the source is masked. `IntCause` holds through SERVICE.
- Ignored inputs:
  - `EPCWrite` in IDLE or SERVICE.
  - `IntReturn` in IDLE or REQ.
  - `IntReturn` and `EPCWrite` both high in REQ: only `EPCWrite` is acted on.
- Masking does not clear pending bits. A masked pending source is taken as soon as it is unmasked and the FSM is in IDLE.
- Reset values: state IDLE, `Pending` = 0000, `Mask` = 0000 (all disabled), `IntCause` = 00, `InterruptIn` = 0, `InterruptHandler` = 0.

## Timing
- All outputs are decoded from registered state. There is no combinational path from input to output.
- `IRQ[i]` first sampled high at edge k: `Pending[i]` = 1 after edge k.
- If the FSM is in IDLE and the source is unmasked, `InterruptIn` = 1 and `IntCause` is valid after edge k+1. Request latency is 2 edges.
- `EPCWrite` sampled high at edge m in REQ:
  - `InterruptIn` = 0, `InterruptHandler` = 1, and the pending bit is cleared after edge m.
- `IntReturn` sampled at edge r in SERVICE: IDLE after edge r.
  - If another eligible source exists, `InterruptIn` rises after edge r+1. IDLE always lasts at least one cycle.
- `MaskWrite` at edge w: the new mask affects arbitration from the cycle after edge w.
- `CLR` high at any edge, including mid-REQ or mid-SERVICE, forces all reset values after that edge. Lost pending requests are not recovered.

## Test plan
- **Basic request.** Reset; `MaskData` = 1111; rise on `IRQ[2]`.
  - Expect `Pending` = 0100, then `InterruptIn` = 1 with `IntCause` = 10 two edges after the rise.
  - `EPCWrite` pulse: expect `Pending` = 0000, `InterruptHandler` = 1.
  - `IntReturn` pulse: expect IDLE with both outputs 0.
- **Priority.** Mask 1111; rise on `IRQ[3]` and `IRQ[1]` in the same cycle.
  - Expect `IntCause` = 01.
  - After ack and return, expect a second request with `IntCause` = 11.
- **Masking.** Mask 0000; rise on `IRQ[0]`.
  - Expect `Pending` = 0001 and `InterruptIn` = 0 for 10 cycles.
  - Write mask 0001: expect `InterruptIn` = 1 two edges after the write edge.
- **No nesting, set-wins.** In SERVICE for cause 00, raise `IRQ[0]` again on the ack edge.
  - Expect `Pending[0]` = 1 and `InterruptIn` = 0 until `IntReturn`.
  - After return, expect a new request with cause 00.
- **Reset behaviour.** Hold `IRQ` = 1111 through `CLR`; release.
  - Expect `Pending` = 0000 and no request.
  - Then assert `CLR` mid-REQ: expect all outputs at reset values after that edge.
- **Ignored strobes.** `EPCWrite` in IDLE and `IntReturn` in REQ: expect no state change and `Pending` unchanged.
